// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: stalls the pipeline while a load or
// store is outstanding, reports misaligned addresses and bounds the wait for mem_ack.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  Min,
  input  logic [31:0] ALUin,
  input  logic [31:0] WDin,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] RDout,
  output logic        misalign,
  output logic        timeout_err
);

  localparam logic [7:0] TERM_CNT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdout;
  logic        r_timeout_err;

  logic w_access;
  logic w_misaligned;
  logic w_accept;
  logic w_misalign;
  logic w_ack;
  logic w_tmo;

  assign w_access     = (Min == 2'b10) || (Min == 2'b01);
  assign w_misaligned = (ALUin[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A coincident ack on the terminal count wins over the timeout.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_misalign = 1'b0;
    w_ack      = 1'b0;
    w_tmo      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          if (w_misaligned) begin
            w_misalign = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_next   = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          w_ack  = 1'b1;
          w_next = DONE;
        end else if (r_cnt == TERM_CNT) begin
          w_tmo  = 1'b1;
          w_next = DONE;
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdout       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_tmo;
      if (w_accept) begin
        r_addr  <= ALUin;
        r_wdata <= WDin;
        r_we    <= (Min == 2'b01);
        r_cnt   <= '0;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_ack && !r_we) begin
        r_rdout <= mem_rdata;
      end else if (w_tmo && !r_we) begin
        r_rdout <= '0;
      end
    end
  end

  // Combinational outputs are masked by rst so reset silences them immediately.
  assign stall       = !rst && ((r_state == BUSY) || w_accept);
  assign misalign    = !rst && w_misalign;
  assign mem_req     = (r_state == BUSY);
  assign mem_we      = (r_state == BUSY) && r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign RDout       = r_rdout;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized scoreboard bench for mem_access_ctrl: the driver pushes the expected
// outcome of each access, a negedge monitor pops it when the access completes.
module tb_mem_access_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  Min;
  logic [31:0] ALUin;
  logic [31:0] WDin;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] RDout;
  logic        misalign;
  logic        timeout_err;

  mem_access_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .Min(Min), .ALUin(ALUin), .WDin(WDin),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .RDout(RDout),
    .misalign(misalign), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mis;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          we;
    bit          tmo;
    int          stall_n;
    int          req_n;
  } exp_t;

  exp_t        q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] model_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},     {31'b0, mem_req},     32'd0);
    chk({tag, "_mem_we"},      {31'b0, mem_we},      32'd0);
    chk({tag, "_mem_addr"},    mem_addr,             32'd0);
    chk({tag, "_mem_wdata"},   mem_wdata,            32'd0);
    chk({tag, "_RDout"},       RDout,                32'd0);
    chk({tag, "_stall"},       {31'b0, stall},       32'd0);
    chk({tag, "_misalign"},    {31'b0, misalign},    32'd0);
    chk({tag, "_timeout_err"}, {31'b0, timeout_err}, 32'd0);
  endtask

  // One instruction in the MEM stage; k >= TMO means memory never acknowledges.
  task automatic do_txn(input logic [1:0] min, input logic [31:0] addr,
                        input logic [31:0] wdata, input int k, input logic [31:0] rdata);
    exp_t e;
    bit   is_ld;
    bit   acked;
    int   nb;
    is_ld = (min == 2'b10);
    Min = min; ALUin = addr; WDin = wdata; mem_ack = 1'b0;
    if (!(is_ld || min == 2'b01)) begin
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      tick();
      mem_ack = 1'b0; Min = 2'b00;
      return;
    end
    e = '{mis: 1'b0, addr: addr, wdata: wdata, rd: model_rd, we: !is_ld,
          tmo: 1'b0, stall_n: 0, req_n: 0};
    if (addr[1:0] != 2'b00) begin
      e.mis = 1'b1;
      q.push_back(e);
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      tick();
      mem_ack = 1'b0; Min = 2'b00;
      return;
    end
    acked     = (k < TMO);
    nb        = acked ? k + 1 : TMO;
    e.tmo     = !acked;
    e.req_n   = nb;
    e.stall_n = nb + 1;
    if (is_ld) e.rd = acked ? rdata : 32'h0;
    model_rd = e.rd;
    q.push_back(e);
    for (int i = 0; i < nb; i++) begin
      tick();
      mem_ack   = acked && (i == k);
      mem_rdata = (acked && (i == k)) ? rdata : $urandom;
    end
    tick();
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    tick();
    mem_ack = 1'b0; Min = 2'b00;
  endtask

  // Monitor
  logic        prev_req = 1'b0;
  logic        unstable = 1'b0;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wd;
  int          stall_run = 0;
  int          req_run = 0;
  exp_t        me;

  always @(negedge clk) begin
    if (rst) begin
      prev_req  = 1'b0;
      stall_run = 0;
      req_run   = 0;
    end else begin
      if (stall) stall_run++;
      if (mem_req) begin
        if (!prev_req) begin
          cap_addr = mem_addr; cap_wd = mem_wdata; cap_we = mem_we; unstable = 1'b0;
        end else if (mem_addr !== cap_addr || mem_wdata !== cap_wd || mem_we !== cap_we) begin
          unstable = 1'b1;
        end
        req_run++;
      end
      if (misalign) begin
        if (q.size() == 0) begin
          chk("unexpected_misalign", {31'b0, misalign}, 32'd0);
        end else begin
          me = q.pop_front();
          chk("misalign_kind", {31'b0, misalign}, {31'b0, me.mis});
          chk("misalign_stall", stall_run, 32'd0);
          chk("misalign_req", {31'b0, mem_req}, 32'd0);
        end
        stall_run = 0;
      end
      if (prev_req && !mem_req) begin
        if (q.size() == 0) begin
          chk("unexpected_done", {31'b0, prev_req}, 32'd0);
        end else begin
          me = q.pop_front();
          chk("done_kind", {31'b0, me.mis}, 32'd0);
          chk("mem_addr", cap_addr, me.addr);
          chk("mem_wdata", cap_wd, me.wdata);
          chk("mem_we", {31'b0, cap_we}, {31'b0, me.we});
          chk("req_stable", {31'b0, unstable}, 32'd0);
          chk("RDout", RDout, me.rd);
          chk("timeout_err", {31'b0, timeout_err}, {31'b0, me.tmo});
          chk("stall_cycles", stall_run, me.stall_n);
          chk("req_cycles", req_run, me.req_n);
        end
        stall_run = 0;
        req_run   = 0;
      end else if (timeout_err) begin
        chk("spurious_timeout_err", {31'b0, timeout_err}, 32'd0);
      end
      prev_req = mem_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rmin;
    logic [31:0] raddr;
    int          r;
    rst = 1'b1; Min = 2'b00; ALUin = '0; WDin = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_rd = 32'h0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    do_txn(2'b10, 32'h0000_0010, 32'h5555_AAAA, 2, 32'hCAFE_F00D);
    do_txn(2'b01, 32'h0000_0020, 32'h1234_5678, 0, 32'hDEAD_BEEF);
    do_txn(2'b10, 32'h0000_0006, 32'h0, 0, 32'h0);
    do_txn(2'b10, 32'h0000_0030, 32'h0, TMO, 32'h1111_2222);
    do_txn(2'b10, 32'h0000_0034, 32'h0, TMO - 1, 32'hA5A5_0001);
    do_txn(2'b01, 32'h0000_0040, 32'hFFFF_0000, TMO, 32'h0);
    do_txn(2'b00, 32'h0000_0003, 32'h0, 0, 32'h0);
    do_txn(2'b11, 32'h0000_0044, 32'h0, 0, 32'h0);
    do_txn(2'b01, 32'h0000_0047, 32'h0, 0, 32'h0);

    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      rmin = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
      raddr = $urandom;
      if ($urandom_range(0, 4) != 0) raddr[1:0] = 2'b00;
      do_txn(rmin, raddr, $urandom, int'($urandom_range(0, TMO + 1)), $urandom);
    end

    // Reset on the second BUSY cycle, then a late ack that must be ignored.
    Min = 2'b10; ALUin = 32'h0000_0080; WDin = 32'h0; mem_ack = 1'b0;
    tick();
    tick();
    #1 rst = 1'b1;
    #1;
    chk_all_zero("rst_busy");
    Min = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h7777_8888;
    repeat (3) begin
      tick();
      chk("late_ack_req", {31'b0, mem_req}, 32'd0);
      chk("late_ack_RDout", RDout, 32'd0);
    end
    mem_ack = 1'b0;
    model_rd = 32'h0;

    do_txn(2'b10, 32'h0000_0090, 32'h0, 1, 32'h0BAD_CAFE);
    repeat (3) tick();
    chk("queue_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of BUSY cycles to wait for mem_ack (range 1-255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port Min, input, 2 bits: the MEM control field from the EX/MEM register; bit 1 = MemRead, bit 0 = MemWrite.
REQ-005 SHALL have port ALUin, input, 32 bits: the byte address from the EX/MEM register.
REQ-006 SHALL have port WDin, input, 32 bits: the store data from the EX/MEM register.
REQ-007 SHALL have ports mem_req, mem_we (outputs, 1 bit each), mem_addr and mem_wdata (outputs, 32 bits each): the data-memory request bus.
REQ-008 SHALL have ports mem_ack (input, 1 bit) and mem_rdata (input, 32 bits): the data-memory response.
REQ-009 SHALL have port stall, output, 1 bit: a hold request to the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-010 SHALL have port RDout, output, 32 bits: load data for the MEM/WB register.
REQ-011 SHALL have ports misalign and timeout_err, outputs, 1 bit each: single-cycle error pulses.

Function
REQ-012 SHALL use a three-state FSM: IDLE, BUSY and DONE.
REQ-013 SHALL treat Min=2'b10 as a load and Min=2'b01 as a store; Min=2'b00 and Min=2'b11 SHALL cause no access, no stall and no error.
REQ-014 SHALL treat an access as misaligned when ALUin[1:0] != 2'b00.
REQ-015 In IDLE, on a misaligned load or store: SHALL make no memory access, SHALL set stall=0, and SHALL pulse misalign for that one cycle.
REQ-016 In IDLE, on an aligned load or store: SHALL drive stall=1 combinationally in that cycle, SHALL latch ALUin, WDin and the write flag, and SHALL move to BUSY.
REQ-017 In BUSY: SHALL hold mem_req=1, and SHALL drive mem_addr, mem_wdata and mem_we from the latched values, stable until the transfer ends.
REQ-018 In BUSY: SHALL hold stall=1.
REQ-019 In BUSY: SHALL run a cycle counter that clears on entry and increments each cycle.
REQ-020 When mem_ack=1 in BUSY: SHALL capture mem_rdata into RDout (loads only; stores leave RDout unchanged), SHALL drop mem_req in the next state, and SHALL move to DONE.
REQ-021 When the counter reaches TIMEOUT-1 with mem_ack=0: SHALL pulse timeout_err, SHALL set RDout=32'h0 for a load, and SHALL move to DONE.
REQ-022 When mem_ack=1 coincides with the terminal count, SHALL treat the transfer as a normal acknowledgement and SHALL NOT raise timeout_err.
REQ-023 DONE SHALL last exactly one cycle with stall=0 and mem_req=0, so the pipeline advances.
REQ-024 In DONE, SHALL ignore Min, ALUin and WDin, because they still hold the completed access; SHALL return to IDLE.
REQ-025 SHALL ignore mem_ack outside BUSY.
REQ-026 SHALL hold RDout between captures.
REQ-027 Total stall for an access acknowledged k cycles after mem_req rises SHALL be k+2 cycles (IDLE cycle plus k+1 BUSY cycles).
REQ-028 When mem_req=0, SHALL hold mem_addr and mem_wdata at their last values.

Reset
REQ-029 When rst=1 at any time, including mid-BUSY, SHALL immediately force: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, RDout=0, stall=0, misalign=0, timeout_err=0, counter=0.
REQ-030 After rst deasserts, SHALL NOT replay an in-flight transfer.

Verification
REQ-031 Load: Min=2'b10, ALUin=32'h0000_0010, memory acks 2 cycles after req with mem_rdata=32'hCAFE_F00D -> mem_addr=32'h10, mem_we=0, stall high 4 cycles, RDout=32'hCAFE_F00D in DONE.
REQ-032 Store: Min=2'b01, ALUin=32'h20, WDin=32'h1234_5678, ack on first BUSY cycle -> mem_we=1, mem_wdata=32'h1234_5678, stall high 2 cycles, RDout unchanged.
REQ-033 Misaligned: Min=2'b10, ALUin=32'h0000_0006 -> misalign pulses 1 cycle, mem_req stays 0, stall stays 0.
REQ-034 Timeout: TIMEOUT=4, load with no ack -> mem_req high 4 cycles, timeout_err pulses once, RDout=0, stall released in DONE.
REQ-035 Reset in BUSY: assert rst on the 2nd BUSY cycle -> mem_req and stall drop asynchronously, all outputs 0, FSM in IDLE; a late mem_ack is ignored.
REQ-036 Ack on terminal count: TIMEOUT=3, mem_ack=1 on BUSY cycle 3 -> data captured, timeout_err stays 0.
